instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port start  input  1  one-cycle pulse; clears the write address and begins a program load.
REQ-004 SHALL have port finish  input  1  one-cycle pulse; ends the load early.
REQ-005 SHALL have port in_valid  input  1  encode request present.
REQ-006 SHALL have port in_ready  output  1  request accepted this cycle when in_valid is also high.
REQ-007 SHALL have port in_kind  input  1  0 = run type, 1 = put type.
REQ-008 SHALL have port in_op  input  4  run-type opcode; ignored for put type.
REQ-009 SHALL have port in_field  input  8  operand; put value for put type, register index for run type.
REQ-010 SHALL have port wr_en  output  1  instruction-memory write strobe.
REQ-011 SHALL have port wr_addr  output  PROG_AW  instruction-memory write address.
REQ-012 SHALL have port wr_data  output  9  encoded instruction word.
REQ-013 SHALL have port busy  output  1  high in LOAD.
REQ-014 SHALL have port done  output  1  high in DONE.
REQ-015 SHALL have port err  output  1  high in ERR.
REQ-016 SHALL have port count  output  PROG_AW+1  number of words written in current load.

Function
REQ-017 Run-type word SHALL be {in_field[3:0], in_op, 1'b0}; put-type word SHALL be {in_field, 1'b1}.
REQ-018 Legal run opcodes SHALL be 0000-1101; 1110 and 1111 SHALL be illegal.
REQ-019 Run-type request with in_field[7:4] != 0 SHALL be illegal.
REQ-020 FSM states SHALL be IDLE, LOAD, DONE, ERR.
REQ-021 IDLE/DONE/ERR SHALL go to LOAD on start; LOAD SHALL go to LOAD on start (restart, address cleared).
REQ-022 in_ready SHALL equal (state == LOAD) && !start && !finish.
REQ-023 Accepted legal request SHALL produce wr_en = 1 with wr_data/wr_addr registered exactly one cycle after acceptance; wr_en SHALL be 0 in all other cycles.
REQ-024 wr_addr SHALL increment by one after each write; count SHALL equal writes since last start.
REQ-025 Write to address PROG_DEPTH-1 SHALL move LOAD to DONE in the same edge; no address wrap-around occurs.
REQ-026 finish in LOAD SHALL move to DONE; finish outside LOAD SHALL be ignored.
REQ-027 Accepted illegal request SHALL cause no write and move LOAD to ERR; ERR SHALL be sticky until start.
REQ-028 start and finish high together SHALL act as start only.
REQ-029 start SHALL never be blocked by in_valid; a request presented in the start cycle is not accepted.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, wr_en 0, wr_addr 0, wr_data 0, count 0, in_ready 0, busy/done/err 0.
REQ-031 Reset during LOAD SHALL abandon the load; a write pending from the prior cycle SHALL NOT be issued.

Configuration
REQ-032 With ENCODER_CHECKSUM_EN defined, output chk (9 bits) SHALL hold the XOR of all wr_data written since start, cleared by start and reset, updated on the wr_en cycle.
REQ-033 Without ENCODER_CHECKSUM_EN, the chk port and its logic SHALL be absent.

Structure
REQ-034 Shared package isa_pkg SHALL hold the opcode enum (LI, LD, ST, ADD, SUB, XOR, OR, AND, JMP, BEQ, BLT, BGT, LSL, LSR), ITYPE_RUN/ITYPE_PUT, PROG_DEPTH = 1024, and PROG_AW = 10.
REQ-035 Combinational sub-module instr_pack SHALL perform word packing and legality checking; the FSM, counters and registers live in instr_encoder.

Verification
REQ-036 start, then run ADD (0011) with field 3 -> next cycle wr_en = 1, wr_addr 0, wr_data 9'h066; count = 1.
REQ-037 put with field 8'hA5 as the second request -> wr_data 9'h14B at wr_addr 1.
REQ-038 run op 1110 -> no write, err = 1, in_ready = 0; later start -> LOAD, wr_addr 0.
REQ-039 1024 back-to-back legal requests -> last write at wr_addr 1023, done = 1, count = 1024, in_ready = 0.
REQ-040 rst_n low for one cycle mid-load after 5 writes -> all outputs 0, state IDLE, no further wr_en.
REQ-041 ENCODER_CHECKSUM_EN defined, writes 9'h066 then 9'h14B -> chk = 9'h12D.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder: opcodes, instruction
// types, program memory geometry and the encoder FSM state type.
package isa_pkg;

   localparam int PROG_DEPTH = 1024;
   localparam int PROG_AW    = 10;

   typedef enum logic [3:0] {
      LI, LD, ST, ADD, SUB, XOR, OR, AND, JMP, BEQ, BLT, BGT, LSL, LSR
   } opcode_e;

   typedef enum logic {
      ITYPE_RUN = 1'b0,
      ITYPE_PUT = 1'b1
   } itype_e;

   typedef enum logic [1:0] {
      S_IDLE, S_LOAD, S_DONE, S_ERR
   } state_e;

   typedef struct packed {
      logic       kind;
      logic [3:0] op;
      logic [7:0] field;
   } enc_req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request/write bus of the instruction encoder. The chk signal exists only
// when ENCODER_CHECKSUM_EN is defined.
interface instr_encoder_if;
   import isa_pkg::*;

   logic               start;
   logic               finish;
   logic               in_valid;
   logic               in_ready;
   logic               in_kind;
   logic [3:0]         in_op;
   logic [7:0]         in_field;
   logic               wr_en;
   logic [PROG_AW-1:0] wr_addr;
   logic [8:0]         wr_data;
   logic               busy;
   logic               done;
   logic               err;
   logic [PROG_AW:0]   count;
`ifdef ENCODER_CHECKSUM_EN
   logic [8:0]         chk;

   modport master (
      output start, finish, in_valid, in_kind, in_op, in_field,
      input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, count, chk
   );
   modport slave (
      input  start, finish, in_valid, in_kind, in_op, in_field,
      output in_ready, wr_en, wr_addr, wr_data, busy, done, err, count, chk
   );
`else
   modport master (
      output start, finish, in_valid, in_kind, in_op, in_field,
      input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, count
   );
   modport slave (
      input  start, finish, in_valid, in_kind, in_op, in_field,
      output in_ready, wr_en, wr_addr, wr_data, busy, done, err, count
   );
`endif
endinterface

// File: rtl/instr_pack.sv
// Combinational instruction word packing and legality check.
module instr_pack
   import isa_pkg::*;
(
   input  enc_req_t   req,
   output logic [8:0] word,
   output logic       legal
);

   always_comb begin
      word  = '0;
      legal = 1'b0;
      if (req.kind == ITYPE_PUT) begin
         word  = {req.field, 1'b1};
         legal = 1'b1;
      end else begin
         // Run words carry only a 4-bit register index; a wider field is illegal.
         word  = {req.field[3:0], req.op, 1'b0};
         legal = (req.op <= LSR) && (req.field[7:4] == 4'd0);
      end
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes requests into 9-bit words and streams them into
// instruction memory. Define ENCODER_CHECKSUM_EN to add the chk XOR output.
module instr_encoder
   import isa_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   instr_encoder_if.slave bus
);

   localparam logic [PROG_AW:0]   LAST_CNT  = (PROG_AW+1)'(PROG_DEPTH-1);
   localparam logic [PROG_AW-1:0] LAST_ADDR = PROG_AW'(PROG_DEPTH-1);

   state_e     state, nxt;
   enc_req_t   req;
   logic [8:0] word;
   logic       legal;
   logic       rdy, accept, wr_ok;

   assign req    = '{kind: bus.in_kind, op: bus.in_op, field: bus.in_field};
   assign accept = bus.in_valid && rdy;
   assign wr_ok  = accept && legal;

   instr_pack u_pack (
      .req   (req),
      .word  (word),
      .legal (legal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (bus.start)
         nxt = S_LOAD;
      else if (state == S_LOAD) begin
         if (bus.finish)
            nxt = S_DONE;
         else if (accept && !legal)
            nxt = S_ERR;
         else if (accept && bus.count == LAST_CNT)
            nxt = S_DONE;
      end
   end

   always_comb begin
      rdy      = (state == S_LOAD) && !bus.start && !bus.finish;
      bus.busy = (state == S_LOAD);
      bus.done = (state == S_DONE);
      bus.err  = (state == S_ERR);
   end

   assign bus.in_ready = rdy;

   // wr_addr is the write pointer: it shows the address during the write
   // cycle, then advances, holding at the last location instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wr_en   <= 1'b0;
         bus.wr_data <= '0;
         bus.wr_addr <= '0;
         bus.count   <= '0;
      end else begin
         bus.wr_en <= wr_ok;
         if (wr_ok) bus.wr_data <= word;
         if (bus.start) begin
            bus.wr_addr <= '0;
            bus.count   <= '0;
         end else begin
            if (bus.wr_en && bus.wr_addr != LAST_ADDR)
               bus.wr_addr <= bus.wr_addr + PROG_AW'(1);
            if (wr_ok)
               bus.count <= bus.count + (PROG_AW+1)'(1);
         end
      end
   end

`ifdef ENCODER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        bus.chk <= '0;
      else if (bus.start) bus.chk <= '0;
      else if (wr_ok)    bus.chk <= bus.chk ^ word;
   end
`endif

endmodule
